// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_register
//  Brief    : DEPTH x WIDTH multi-lane shift register with hold, shift
//             right/left, rotate right/left and parallel load. A modulo-DEPTH
//             operation counter emits a one-cycle frame_done pulse each time
//             it wraps.
//  Revision : 1.0  initial release
// ============================================================================
module universal_shift_register #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       serial_in,
    input  logic [DEPTH*WIDTH-1:0] parallel_in,
    output logic [DEPTH*WIDTH-1:0] out,
    output logic [WIDTH-1:0]       serial_out_right,
    output logic [WIDTH-1:0]       serial_out_left,
    output logic [CW-1:0]          count,
    output logic                   frame_done
);

    // Mode encodings; 6 and 7 are reserved and fall through to hold.
    localparam logic [2:0] c_HOLD = 3'd0;
    localparam logic [2:0] c_SHR  = 3'd1;
    localparam logic [2:0] c_SHL  = 3'd2;
    localparam logic [2:0] c_ROR  = 3'd3;
    localparam logic [2:0] c_ROL  = 3'd4;
    localparam logic [2:0] c_LOAD = 3'd5;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(DEPTH - 1);

    // Element i lives at [i], so the packed array maps 1:1 onto out.
    logic [DEPTH-1:0][WIDTH-1:0] elem_q;
    logic [DEPTH-1:0][WIDTH-1:0] elem_d;
    logic [CW-1:0]               count_q;
    logic [CW-1:0]               count_d;
    logic                        frame_q;
    logic                        frame_d;
    logic                        w_is_shift;

    // Next-state: data movement per mode, then counter advance on shift/rotate.
    always_comb begin
        elem_d     = elem_q;
        count_d    = count_q;
        frame_d    = 1'b0;
        w_is_shift = 1'b0;

        if (enable) begin
            case (mode)
                c_HOLD: ;
                c_SHR: begin
                    elem_d     = {serial_in, elem_q[DEPTH-1:1]};
                    w_is_shift = 1'b1;
                end
                c_SHL: begin
                    elem_d     = {elem_q[DEPTH-2:0], serial_in};
                    w_is_shift = 1'b1;
                end
                c_ROR: begin
                    elem_d     = {elem_q[0], elem_q[DEPTH-1:1]};
                    w_is_shift = 1'b1;
                end
                c_ROL: begin
                    elem_d     = {elem_q[DEPTH-2:0], elem_q[DEPTH-1]};
                    w_is_shift = 1'b1;
                end
                c_LOAD: begin
                    // A load wins over a pending wrap: no pulse, count restarts.
                    elem_d  = parallel_in;
                    count_d = '0;
                end
                default: ;
            endcase

            if (w_is_shift) begin
                if (count_q == c_CNT_LAST) begin
                    count_d = '0;
                    frame_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            elem_q  <= '0;
            count_q <= '0;
            frame_q <= 1'b0;
        end else begin
            elem_q  <= elem_d;
            count_q <= count_d;
            frame_q <= frame_d;
        end
    end

    assign out              = elem_q;
    assign serial_out_right = elem_q[0];
    assign serial_out_left  = elem_q[DEPTH-1];
    assign count            = count_q;
    assign frame_done       = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_universal_shift_register
//  Brief    : Scoreboard bench for universal_shift_register, exercising a
//             1x8 instance and a 4x4 instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_universal_shift_register;

    logic clk;

    // 1-bit x 8 instance
    logic        reset8, en8;
    logic [2:0]  mode8;
    logic [0:0]  sin8;
    logic [7:0]  pin8;
    logic [7:0]  out8;
    logic [0:0]  sor8, sol8;
    logic [2:0]  cnt8;
    logic        fd8;

    // 4-bit x 4 instance
    logic        reset4, en4;
    logic [2:0]  mode4;
    logic [3:0]  sin4;
    logic [15:0] pin4;
    logic [15:0] out4;
    logic [3:0]  sor4, sol4;
    logic [1:0]  cnt4;
    logic        fd4;

    int total;
    int bad;
    int fd8_seen;

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] cnt;
        logic       fd;
    } exp8_t;

    typedef struct packed {
        logic [15:0] out;
        logic [1:0]  cnt;
        logic        fd;
    } exp4_t;

    exp8_t q8[$];
    exp4_t q4[$];

    logic [7:0]  m8_out;
    logic [2:0]  m8_cnt;
    logic [15:0] m4_out;
    logic [1:0]  m4_cnt;

    universal_shift_register #(.WIDTH(1), .DEPTH(8)) u_dut8 (
        .clk              (clk),
        .reset            (reset8),
        .enable           (en8),
        .mode             (mode8),
        .serial_in        (sin8),
        .parallel_in      (pin8),
        .out              (out8),
        .serial_out_right (sor8),
        .serial_out_left  (sol8),
        .count            (cnt8),
        .frame_done       (fd8)
    );

    universal_shift_register #(.WIDTH(4), .DEPTH(4)) u_dut4 (
        .clk              (clk),
        .reset            (reset4),
        .enable           (en4),
        .mode             (mode4),
        .serial_in        (sin4),
        .parallel_in      (pin4),
        .out              (out4),
        .serial_out_right (sor4),
        .serial_out_left  (sol4),
        .count            (cnt4),
        .frame_done       (fd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the 1x8 instance: predict, push, clock, pop, compare.
    task automatic cyc8(input logic r, input logic e, input logic [2:0] md,
                        input logic s, input logic [7:0] p);
        exp8_t x;
        logic  sh;
        logic  wrap;
        reset8 = r; en8 = e; mode8 = md; sin8 = s; pin8 = p;
        sh = 1'b0; wrap = 1'b0;
        if (r) begin
            m8_out = 8'h00; m8_cnt = 3'd0;
        end else if (e) begin
            case (md)
                3'd1: begin m8_out = {s, m8_out[7:1]};         sh = 1'b1; end
                3'd2: begin m8_out = {m8_out[6:0], s};         sh = 1'b1; end
                3'd3: begin m8_out = {m8_out[0], m8_out[7:1]}; sh = 1'b1; end
                3'd4: begin m8_out = {m8_out[6:0], m8_out[7]}; sh = 1'b1; end
                3'd5: begin m8_out = p; m8_cnt = 3'd0; end
                default: ;
            endcase
            if (sh) begin
                if (m8_cnt == 3'd7) begin m8_cnt = 3'd0; wrap = 1'b1; end
                else m8_cnt = m8_cnt + 3'd1;
            end
        end
        x.out = m8_out; x.cnt = m8_cnt; x.fd = wrap;
        q8.push_back(x);
        @(posedge clk); #1;
        x = q8.pop_front();
        total++;
        if (out8 !== x.out) begin bad++; $display("FAIL sb8_out: got %h want %h", out8, x.out); end
        total++;
        if (cnt8 !== x.cnt) begin bad++; $display("FAIL sb8_count: got %0d want %0d", cnt8, x.cnt); end
        total++;
        if (fd8 !== x.fd) begin bad++; $display("FAIL sb8_frame_done: got %b want %b", fd8, x.fd); end
        total++;
        if (sor8 !== x.out[0]) begin bad++; $display("FAIL sb8_sor: got %b want %b", sor8, x.out[0]); end
        total++;
        if (sol8 !== x.out[7]) begin bad++; $display("FAIL sb8_sol: got %b want %b", sol8, x.out[7]); end
        if (fd8 === 1'b1) fd8_seen++;
    endtask

    // One clock of the 4x4 instance.
    task automatic cyc4(input logic r, input logic e, input logic [2:0] md,
                        input logic [3:0] s, input logic [15:0] p);
        exp4_t x;
        logic  sh;
        logic  wrap;
        reset4 = r; en4 = e; mode4 = md; sin4 = s; pin4 = p;
        sh = 1'b0; wrap = 1'b0;
        if (r) begin
            m4_out = 16'h0; m4_cnt = 2'd0;
        end else if (e) begin
            case (md)
                3'd1: begin m4_out = {s, m4_out[15:4]};            sh = 1'b1; end
                3'd2: begin m4_out = {m4_out[11:0], s};            sh = 1'b1; end
                3'd3: begin m4_out = {m4_out[3:0], m4_out[15:4]};  sh = 1'b1; end
                3'd4: begin m4_out = {m4_out[11:0], m4_out[15:12]}; sh = 1'b1; end
                3'd5: begin m4_out = p; m4_cnt = 2'd0; end
                default: ;
            endcase
            if (sh) begin
                if (m4_cnt == 2'd3) begin m4_cnt = 2'd0; wrap = 1'b1; end
                else m4_cnt = m4_cnt + 2'd1;
            end
        end
        x.out = m4_out; x.cnt = m4_cnt; x.fd = wrap;
        q4.push_back(x);
        @(posedge clk); #1;
        x = q4.pop_front();
        total++;
        if (out4 !== x.out) begin bad++; $display("FAIL sb4_out: got %h want %h", out4, x.out); end
        total++;
        if (cnt4 !== x.cnt) begin bad++; $display("FAIL sb4_count: got %0d want %0d", cnt4, x.cnt); end
        total++;
        if (fd4 !== x.fd) begin bad++; $display("FAIL sb4_frame_done: got %b want %b", fd4, x.fd); end
        total++;
        if (sor4 !== x.out[3:0]) begin bad++; $display("FAIL sb4_sor: got %h want %h", sor4, x.out[3:0]); end
        total++;
        if (sol4 !== x.out[15:12]) begin bad++; $display("FAIL sb4_sol: got %h want %h", sol4, x.out[15:12]); end
    endtask

    task automatic test_reset();
        cyc8(1'b1, 1'b1, 3'd5, 1'b1, 8'hFF);
        total++;
        if ({out8, cnt8, fd8, sor8, sol8} !== 13'h0) begin
            bad++; $display("FAIL reset_state: got out=%h cnt=%0d fd=%b want all zero", out8, cnt8, fd8);
        end
        cyc4(1'b1, 1'b1, 3'd5, 4'hF, 16'hFFFF);
        total++;
        if (out4 !== 16'h0 || cnt4 !== 2'd0) begin
            bad++; $display("FAIL reset4_state: got out=%h cnt=%0d want 0", out4, cnt4);
        end
    endtask

    task automatic test_shr();
        logic [7:0] pat;
        pat = 8'b0100_1101;               // bit i = i-th serial_in value
        cyc8(1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cyc8(1'b0, 1'b1, 3'd1, pat[i], 8'h00);
        total++;
        if (out8 !== 8'b0100_1101 || fd8 !== 1'b1 || cnt8 !== 3'd0) begin
            bad++; $display("FAIL shr_frame: got out=%b fd=%b cnt=%0d want 01001101 1 0", out8, fd8, cnt8);
        end
        cyc8(1'b0, 1'b1, 3'd0, 1'b0, 8'h00);
        total++;
        if (fd8 !== 1'b0) begin bad++; $display("FAIL shr_pulse_width: got %b want 0", fd8); end
    endtask

    task automatic test_rotate();
        cyc4(1'b1, 1'b0, 3'd0, 4'h0, 16'h0);
        cyc4(1'b0, 1'b1, 3'd5, 4'h0, 16'h4321);
        cyc4(1'b0, 1'b1, 3'd3, 4'hA, 16'h0);
        total++;
        if (out4 !== 16'h1432) begin bad++; $display("FAIL ror_value: got %h want 1432", out4); end
        cyc4(1'b0, 1'b1, 3'd4, 4'hB, 16'h0);
        cyc4(1'b0, 1'b1, 3'd4, 4'hC, 16'h0);
        total++;
        if (out4 !== 16'h3214 || sor4 !== 4'h4) begin
            bad++; $display("FAIL rol_value: got out=%h sor=%h want 3214 4", out4, sor4);
        end
        // Fourth op of the frame: wraps the 4-deep counter.
        cyc4(1'b0, 1'b1, 3'd2, 4'h9, 16'h0);
        total++;
        if (out4 !== 16'h2149 || fd4 !== 1'b1) begin
            bad++; $display("FAIL shl4_wrap: got out=%h fd=%b want 2149 1", out4, fd4);
        end
    endtask

    task automatic test_shl_serialize();
        logic [7:0] src;
        src = 8'hA5;
        cyc8(1'b0, 1'b1, 3'd5, 1'b0, src);
        fd8_seen = 0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sol8 !== src[7-i]) begin
                bad++; $display("FAIL shl_sol_bit%0d: got %b want %b", i, sol8, src[7-i]);
            end
            cyc8(1'b0, 1'b1, 3'd2, 1'b0, 8'h00);
        end
        total++;
        if (out8 !== 8'h00 || fd8_seen != 1) begin
            bad++; $display("FAIL shl_end: got out=%h pulses=%0d want 00 1", out8, fd8_seen);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] snap;
        cyc8(1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc8(1'b0, 1'b1, 3'd1, 1'b1, 8'h00);
        snap = out8;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) cyc8(1'b0, 1'b0, 3'd1, 1'b1, 8'h00);
            else       cyc8(1'b0, 1'b1, 3'd6, 1'b1, 8'h00);
            total++;
            if (out8 !== snap || cnt8 !== 3'd3 || fd8 !== 1'b0) begin
                bad++; $display("FAIL gap_hold%0d: got out=%h cnt=%0d fd=%b want %h 3 0", i, out8, cnt8, fd8, snap);
            end
        end
        for (int i = 0; i < 5; i++) cyc8(1'b0, 1'b1, 3'd1, 1'b0, 8'h00);
        total++;
        if (cnt8 !== 3'd0 || fd8 !== 1'b1) begin
            bad++; $display("FAIL gap_wrap: got cnt=%0d fd=%b want 0 1", cnt8, fd8);
        end
    endtask

    task automatic test_load_collision();
        cyc8(1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) cyc8(1'b0, 1'b1, 3'd1, 1'b0, 8'h00);
        cyc8(1'b0, 1'b1, 3'd5, 1'b0, 8'hFF);
        total++;
        if (out8 !== 8'hFF || cnt8 !== 3'd0 || fd8 !== 1'b0) begin
            bad++; $display("FAIL load_collision: got out=%h cnt=%0d fd=%b want ff 0 0", out8, cnt8, fd8);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) cyc8(1'b0, 1'b1, 3'd1, 1'b1, 8'h00);
        cyc8(1'b1, 1'b1, 3'd1, 1'b1, 8'h00);
        total++;
        if (out8 !== 8'h00 || cnt8 !== 3'd0) begin
            bad++; $display("FAIL midframe_reset: got out=%h cnt=%0d want 00 0", out8, cnt8);
        end
        fd8_seen = 0;
        for (int i = 0; i < 8; i++) cyc8(1'b0, 1'b1, 3'd1, 1'b1, 8'h00);
        total++;
        if (fd8 !== 1'b1 || fd8_seen != 1 || out8 !== 8'hFF) begin
            bad++; $display("FAIL midframe_wrap: got fd=%b pulses=%0d out=%h want 1 1 ff", fd8, fd8_seen, out8);
        end
    endtask

    initial begin
        total = 0; bad = 0; fd8_seen = 0;
        reset8 = 1'b1; en8 = 1'b0; mode8 = 3'd0; sin8 = 1'b0; pin8 = 8'h00;
        reset4 = 1'b1; en4 = 1'b0; mode4 = 3'd0; sin4 = 4'h0; pin4 = 16'h0;
        m8_out = 8'h00; m8_cnt = 3'd0; m4_out = 16'h0; m4_cnt = 2'd0;
        test_reset();
        reset4 = 1'b0;
        test_shr();
        test_rotate();
        en4 = 1'b0;
        test_shl_serialize();
        test_gaps();
        test_load_collision();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
